// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage: FSM encoding, access-size codes
// and the byte-enable generator.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Loads always fetch the whole word; stores enable only the addressed lanes.
    function automatic logic [3:0] byte_enable(input logic we, input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be_v;
        be_v = 4'b0000;
        if (!we) begin
            be_v = 4'b1111;
        end else begin
            case (size)
                SZ_BYTE: be_v = 4'b0001 << addr_lo;
                SZ_HALF: be_v = addr_lo[1] ? 4'b1100 : 4'b0011;
                SZ_WORD: be_v = 4'b1111;
                default: be_v = 4'b0000;
            endcase
        end
        return be_v;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte-enable/data steering, load lane select with
// sign/zero extension, and misalignment detection.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic        we,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store steering and alignment check.
    always_comb begin
        be       = byte_enable(we, size, addr_lo);
        wdata    = 32'h0000_0000;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata    = {4{st_data[7:0]}};
                misalign = 1'b0;
            end
            SZ_HALF: begin
                wdata    = {2{st_data[15:0]}};
                misalign = addr_lo[0];
            end
            SZ_WORD: begin
                wdata    = st_data;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                wdata    = 32'h0000_0000;
                misalign = 1'b1;
            end
        endcase
    end

    // Load lane select followed by extension.
    always_comb begin
        byte_s  = 8'h00;
        half_s  = 16'h0000;
        ld_data = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = rd_data[7:0];
            2'b01:   byte_s = rd_data[15:8];
            2'b10:   byte_s = rd_data[23:16];
            2'b11:   byte_s = rd_data[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rd_data[31:16];
        end else begin
            half_s = rd_data[15:0];
        end
        case (size)
            SZ_BYTE: ld_data = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: ld_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_WORD: ld_data = rd_data;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one load/store per Start over a req/ack data-memory port, with
// alignment check, ack timeout and a registered load result for write-back.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [31:0] ALU_out,
    input  logic [31:0] RF_B,
    input  logic        Mem_WrEn,
    input  logic [1:0]  Mem_Size,
    input  logic        Mem_Unsigned,
    output logic        DM_Req,
    output logic        DM_We,
    output logic [31:0] DM_Addr,
    output logic [3:0]  DM_Be,
    output logic [31:0] DM_Wdata,
    input  logic        DM_Ack,
    input  logic [31:0] DM_Rdata,
    output logic [31:0] MEM_DataOut,
    output logic        Busy,
    output logic        Done,
    output logic        Err_Align,
    output logic        Err_Timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [1:0]        lo_r, lo_nx_s;
    logic [1:0]        size_r, size_nx_s;
    logic              uns_r, uns_nx_s;
    logic              req_r, req_nx_s;
    logic              we_r, we_nx_s;
    logic [31:0]       addr_r, addr_nx_s;
    logic [3:0]        be_r, be_nx_s;
    logic [31:0]       wdata_r, wdata_nx_s;
    logic [31:0]       data_r, data_nx_s;
    logic              busy_r, done_r, err_align_r, err_to_r;
    logic              err_align_nx_s, err_to_nx_s;

    logic              idle_s;
    logic [1:0]        sel_lo_s, sel_size_s;
    logic              sel_uns_s, sel_we_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s, ld_data_s;
    logic              misalign_s;

    // The lane logic sees live inputs while idle and the latched access otherwise.
    always_comb begin
        idle_s     = (state_r == ST_IDLE);
        sel_lo_s   = idle_s ? ALU_out[1:0] : lo_r;
        sel_size_s = idle_s ? Mem_Size     : size_r;
        sel_uns_s  = idle_s ? Mem_Unsigned : uns_r;
        sel_we_s   = idle_s ? Mem_WrEn     : we_r;
    end

    mem_lane_align u_lane (
        .addr_lo     (sel_lo_s),
        .size        (sel_size_s),
        .is_unsigned (sel_uns_s),
        .we          (sel_we_s),
        .st_data     (RF_B),
        .rd_data     (DM_Rdata),
        .be          (be_s),
        .wdata       (wdata_s),
        .ld_data     (ld_data_s),
        .misalign    (misalign_s)
    );

    // Next-state and next-output computation.
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        lo_nx_s        = lo_r;
        size_nx_s      = size_r;
        uns_nx_s       = uns_r;
        req_nx_s       = req_r;
        we_nx_s        = we_r;
        addr_nx_s      = addr_r;
        be_nx_s        = be_r;
        wdata_nx_s     = wdata_r;
        data_nx_s      = data_r;
        err_align_nx_s = 1'b0;
        err_to_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start && misalign_s) begin
                    state_nx_s     = ST_DONE;
                    err_align_nx_s = 1'b1;
                end else if (Start) begin
                    state_nx_s = ST_ACCESS;
                    req_nx_s   = 1'b1;
                    we_nx_s    = Mem_WrEn;
                    addr_nx_s  = {ALU_out[31:2], 2'b00};
                    be_nx_s    = be_s;
                    wdata_nx_s = wdata_s;
                    lo_nx_s    = ALU_out[1:0];
                    size_nx_s  = Mem_Size;
                    uns_nx_s   = Mem_Unsigned;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (DM_Ack) begin
                    state_nx_s = ST_DONE;
                    req_nx_s   = 1'b0;
                    if (!we_r) begin
                        data_nx_s = ld_data_s;
                    end else begin
                        data_nx_s = data_r;
                    end
                end else if (TO_EN && (cnt_r == CNT_LAST)) begin
                    state_nx_s  = ST_DONE;
                    req_nx_s    = 1'b0;
                    err_to_nx_s = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                req_nx_s   = 1'b0;
            end
        endcase
    end

    // State, latches and all output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            lo_r        <= 2'b00;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            be_r        <= 4'b0000;
            wdata_r     <= 32'h0000_0000;
            data_r      <= 32'h0000_0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_align_r <= 1'b0;
            err_to_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            lo_r        <= lo_nx_s;
            size_r      <= size_nx_s;
            uns_r       <= uns_nx_s;
            req_r       <= req_nx_s;
            we_r        <= we_nx_s;
            addr_r      <= addr_nx_s;
            be_r        <= be_nx_s;
            wdata_r     <= wdata_nx_s;
            data_r      <= data_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= (state_nx_s == ST_DONE);
            err_align_r <= err_align_nx_s;
            err_to_r    <= err_to_nx_s;
        end
    end

    assign DM_Req      = req_r;
    assign DM_We       = we_r;
    assign DM_Addr     = addr_r;
    assign DM_Be       = be_r;
    assign DM_Wdata    = wdata_r;
    assign MEM_DataOut = data_r;
    assign Busy        = busy_r;
    assign Done        = done_r;
    assign Err_Align   = err_align_r;
    assign Err_Timeout = err_to_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] alu_out;
    logic [31:0] rf_b;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, data_out;
    logic [3:0]  dm_be;
    logic        busy, done, err_align, err_to;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int req_cycles;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYC(16)) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .Start        (start),
        .ALU_out      (alu_out),
        .RF_B         (rf_b),
        .Mem_WrEn     (wr_en),
        .Mem_Size     (size),
        .Mem_Unsigned (uns),
        .DM_Req       (dm_req),
        .DM_We        (dm_we),
        .DM_Addr      (dm_addr),
        .DM_Be        (dm_be),
        .DM_Wdata     (dm_wdata),
        .DM_Ack       (dm_ack),
        .DM_Rdata     (dm_rdata),
        .MEM_DataOut  (data_out),
        .Busy         (busy),
        .Done         (done),
        .Err_Align    (err_align),
        .Err_Timeout  (err_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one access for a single edge, then drop Start.
    task automatic start_op(input logic [31:0] a, input logic [31:0] d, input logic we,
                            input logic [1:0] sz, input logic u);
        alu_out = a;
        rf_b    = d;
        wr_en   = we;
        size    = sz;
        uns     = u;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_out  = 32'h0;
        rf_b     = 32'h0;
        wr_en    = 1'b0;
        size     = 2'b00;
        uns      = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        #12;
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout", data_out, 32'h0);
        chk("rst_be", {28'd0, dm_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // lw 0x10, ack three cycles after Req rises
        start_op(32'h0000_0010, 32'h0, 1'b0, 2'b10, 1'b0);
        chk("lw_req", {31'd0, dm_req}, 32'd1);
        chk("lw_we", {31'd0, dm_we}, 32'd0);
        chk("lw_addr", dm_addr, 32'h0000_0010);
        chk("lw_be", {28'd0, dm_be}, 32'h0000_000F);
        chk("lw_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
        tick();
        dm_ack   = 1'b0;
        chk("lw_done", {31'd0, done}, 32'd1);
        chk("lw_req_drop", {31'd0, dm_req}, 32'd0);
        chk("lw_data", data_out, 32'hDEAD_BEEF);
        chk("lw_errs", {30'd0, err_align, err_to}, 32'd0);
        tick();
        chk("lw_done_pulse", {31'd0, done}, 32'd0);
        chk("lw_idle", {31'd0, busy}, 32'd0);

        // lb 0x13 signed, then lbu
        start_op(32'h0000_0013, 32'h0, 1'b0, 2'b00, 1'b0);
        chk("lb_be", {28'd0, dm_be}, 32'h0000_000F);
        chk("lb_addr", dm_addr, 32'h0000_0010);
        dm_ack   = 1'b1;
        dm_rdata = 32'h8011_2233;
        tick();
        dm_ack   = 1'b0;
        chk("lb_done", {31'd0, done}, 32'd1);
        chk("lb_data", data_out, 32'hFFFF_FF80);
        tick();
        start_op(32'h0000_0013, 32'h0, 1'b0, 2'b00, 1'b1);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        chk("lbu_data", data_out, 32'h0000_0080);
        tick();

        // sb 0x01
        start_op(32'h0000_0001, 32'h0000_00AB, 1'b1, 2'b00, 1'b0);
        chk("sb_we", {31'd0, dm_we}, 32'd1);
        chk("sb_be", {28'd0, dm_be}, 32'h0000_0002);
        chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
        chk("sb_addr", dm_addr, 32'h0000_0000);
        dm_ack   = 1'b1;
        dm_rdata = 32'h5555_5555;
        tick();
        dm_ack   = 1'b0;
        chk("sb_done", {31'd0, done}, 32'd1);
        chk("sb_dout_kept", data_out, 32'h0000_0080);
        tick();

        // sh 0x02 upper half
        start_op(32'h0000_0002, 32'h1234_CAFE, 1'b1, 2'b01, 1'b0);
        chk("sh_be", {28'd0, dm_be}, 32'h0000_000C);
        chk("sh_wdata", dm_wdata, 32'hCAFE_CAFE);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        tick();

        // lh 0x06 signed, upper half lane
        start_op(32'h0000_0006, 32'h0, 1'b0, 2'b01, 1'b0);
        chk("lh_addr", dm_addr, 32'h0000_0004);
        dm_ack   = 1'b1;
        dm_rdata = 32'h8001_7FFF;
        tick();
        dm_ack   = 1'b0;
        chk("lh_data", data_out, 32'hFFFF_8001);
        tick();

        // misaligned lw 0x02 and lh 0x03, reserved size
        start_op(32'h0000_0002, 32'h0, 1'b0, 2'b10, 1'b0);
        chk("mis_w_req", {31'd0, dm_req}, 32'd0);
        chk("mis_w_done", {31'd0, done}, 32'd1);
        chk("mis_w_err", {31'd0, err_align}, 32'd1);
        chk("mis_w_dout", data_out, 32'hFFFF_8001);
        tick();
        chk("mis_w_clr", {30'd0, done, err_align}, 32'd0);
        start_op(32'h0000_0003, 32'h0, 1'b0, 2'b01, 1'b0);
        chk("mis_h_req", {31'd0, dm_req}, 32'd0);
        chk("mis_h_err", {30'd0, done, err_align}, 32'd3);
        tick();
        start_op(32'h0000_0000, 32'h0, 1'b0, 2'b11, 1'b0);
        chk("rsvd_err", {29'd0, dm_req, done, err_align}, 32'd3);
        tick();

        // no ack: timeout after 16 request cycles
        start_op(32'h0000_0020, 32'h0, 1'b0, 2'b10, 1'b0);
        req_cycles = 0;
        while (dm_req && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {30'd0, err_to, err_align}, 32'd2);
        tick();
        chk("to_clr", {31'd0, err_to}, 32'd0);

        // ack on the 16th cycle wins over the limit
        start_op(32'h0000_0024, 32'h0, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("ack16_req", {31'd0, dm_req}, 32'd1);
        dm_ack   = 1'b1;
        dm_rdata = 32'h0BAD_F00D;
        tick();
        dm_ack   = 1'b0;
        chk("ack16_done", {31'd0, done}, 32'd1);
        chk("ack16_noerr", {30'd0, err_to, err_align}, 32'd0);
        chk("ack16_data", data_out, 32'h0BAD_F00D);
        tick();

        // reset mid-ACCESS
        start_op(32'h0000_0030, 32'h0, 1'b0, 2'b10, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, dm_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_dout", data_out, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();

        // normal access after reset, with a Start pulse while busy ignored
        start_op(32'h0000_0040, 32'h0, 1'b0, 2'b10, 1'b0);
        start_op(32'h0000_0045, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0);
        chk("busy_ign_addr", dm_addr, 32'h0000_0040);
        chk("busy_ign_we", {31'd0, dm_we}, 32'd0);
        chk("busy_ign_be", {28'd0, dm_be}, 32'h0000_000F);
        dm_ack   = 1'b1;
        dm_rdata = 32'h1234_5678;
        tick();
        dm_ack   = 1'b0;
        chk("post_rst_done", {31'd0, done}, 32'd1);
        chk("post_rst_data", data_out, 32'h1234_5678);
        tick();
        chk("post_rst_idle", {30'd0, busy, dm_req}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
